// File: rtl/dm_store_buffer.sv
// In-order word-store buffer between the memory stage and DM.
// Coalesces back-to-back stores to one word and forwards buffered data to loads.
module dm_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [31:0] st_pc,
    output logic        st_ready,
    input  logic [31:0] ld_addr,
    input  logic [31:0] dm_rdata,
    output logic [31:0] ld_data,
    output logic        ld_fwd,
    input  logic        dm_hold,
    output logic        dm_write,
    output logic [31:0] dm_address,
    output logic [31:0] dm_in,
    output logic [31:0] dm_pc,
    output logic        empty
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [29:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [PTR_W-1:0] tail_m1;
    logic             drain;
    logic             push;
    logic             coalesce;
    logic             append;
    logic [CNT_W-1:0] count_nxt;
    logic [PTR_W-1:0] fwd_idx;

    // Byte-offset bits of word addresses carry no information here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{st_addr[1:0], ld_addr[1:0]};

    assign st_ready   = (count < CNT_W'(DEPTH));
    assign empty      = (count == '0);
    assign drain      = (count != '0) && !dm_hold;
    assign dm_write   = drain;
    assign dm_address = {addr_q[head], 2'b00};
    assign dm_in      = data_q[head];
    assign dm_pc      = pc_q[head];

    assign tail_m1  = tail - PTR_W'(1);
    assign push     = st_valid && st_ready;
    // The only entry may not be merged into while it is leaving for DM.
    assign coalesce = push && (count != '0) && (addr_q[tail_m1] == st_addr[31:2])
                      && !((count == CNT_W'(1)) && drain);
    assign append   = push && !coalesce;

    always_comb begin
        count_nxt = count;
        if (append && !drain) begin
            count_nxt = count + CNT_W'(1);
        end else if (!append && drain) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    // Walk oldest to youngest so the youngest matching entry wins.
    always_comb begin
        ld_data = dm_rdata;
        ld_fwd  = 1'b0;
        fwd_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head + PTR_W'(k);
            if ((CNT_W'(k) < count) && (addr_q[fwd_idx] == ld_addr[31:2])) begin
                ld_data = data_q[fwd_idx];
                ld_fwd  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else begin
            count <= count_nxt;
            if (drain) begin
                head <= head + PTR_W'(1);
            end
            if (coalesce) begin
                data_q[tail_m1] <= st_data;
                pc_q[tail_m1]   <= st_pc;
            end
            if (append) begin
                addr_q[tail] <= st_addr[31:2];
                data_q[tail] <= st_data;
                pc_q[tail]   <= st_pc;
                tail         <= tail + PTR_W'(1);
            end
        end
    end

endmodule

// File: doc/dm_store_buffer.md
# dm_store_buffer

Word-store buffer between the execute/memory stage and the data memory `DM`. It accepts word stores from the pipeline, queues them in a small in-order FIFO and drains one per cycle into `DM`'s write port when `DM` is not held. Consecutive stores to the same word coalesce in place. Loads are served by forwarding from the youngest matching buffered store, falling back to `DM`'s combinational read data.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; a power of two, at least 2.
- `PTR_W`, `$clog2(DEPTH)`: pointer width, derived; do not override.

Ports:
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-low reset.
- `st_valid`  in  1  Pipeline presents a word store this cycle.
- `st_addr`  in  32  Store byte address; only [31:2] are used.
- `st_data`  in  32  Store data.
- `st_pc`  in  32  PC of the store instruction; carried through to `dm_pc`.
- `st_ready`  out  1  Buffer can accept a store this cycle.
- `ld_addr`  in  32  Load byte address; only [31:2] are used.
- `dm_rdata`  in  32  `DM` combinational read data at `ld_addr`.
- `ld_data`  out  32  Load result after forwarding.
- `ld_fwd`  out  1  `ld_data` came from the buffer.
- `dm_hold`  in  1  `DM` must not be written this cycle.
- `dm_write`  out  1  Write strobe to `DM`.
- `dm_address`  out  32  Head entry address, with [1:0] driven to 0.
- `dm_in`  out  32  Head entry data.
- `dm_pc`  out  32  Head entry PC.
- `empty`  out  1  No pending stores; the pipeline uses this for fences.

## Operation
- Storage: `DEPTH` entries of {addr[31:2], data, pc}, plus `head`, `tail` (`PTR_W` bits, wrapping modulo `DEPTH`) and `count` (`PTR_W`+1 bits).
- Reset (`reset`=0, takes effect immediately):
  - `head`=`tail`=`count`=0.
  - Outputs: `empty`=1, `st_ready`=1, `dm_write`=0, `ld_fwd`=0.
  - `dm_address`, `dm_in` and `dm_pc` show entry 0, which resets to 0.
  - Any stores pending at reset are discarded and are never written to `DM`.
- `st_ready` = (`count` < `DEPTH`). It depends only on registered state. A full buffer rejects stores even in a cycle when it drains.
- Drain: `drain` = (`count`≠0) & ~`dm_hold`. `dm_write` = `drain`, and `dm_*` show entry[`head`]. On the edge: `head`+1, `count`−1.
- Push (`st_valid` & `st_ready`):
  - Coalesce: if `count`≠0, entry[`tail`−1].addr == `st_addr`[31:2], and not (`count`==1 & `drain`), overwrite that entry's data and pc. `tail` and `count` are unchanged.
  - Otherwise write entry[`tail`], then `tail`+1, `count`+1.
  - When coalescing is blocked because the matching entry drains this cycle, the store is appended as a new entry.
- Simultaneous push and drain: `count` changes by net 0 when appending, or by −1 when coalescing.
- Forwarding, combinational:
  - Compare `ld_addr`[31:2] against every valid entry, including the head entry being drained this cycle.
  - The youngest match (closest to `tail`−1) supplies `ld_data`, and `ld_fwd`=1.
  - With no match, `ld_data`=`dm_rdata` and `ld_fwd`=0.
  - A store pushed in the same cycle is not visible to forwarding.
- `empty` = (`count`==0).
- Stores with `st_valid`=1 and `st_ready`=0 are ignored. The pipeline must stall and hold the store.

## Timing
- Store accepted at edge N is presented on `dm_*` in cycle N+1 at the earliest, and written to `DM` at edge N+1. Minimum latency is 1 cycle; the buffer has no combinational store-to-`DM` path.
- Throughput: 1 push and 1 drain per cycle.
- Forwarding latency is 0 cycles for entries that exist at the start of the cycle.
- `dm_hold`=1 freezes `head`. `dm_*` stay stable on the head entry and `dm_write`=0.
- `st_ready` deasserts in the cycle after the push that fills the buffer. It reasserts in the cycle after the first drain from full.
- Mid-operation reset: all outputs take their reset values asynchronously. The first store accepted after reset release is written to entry 0.

## Test plan
- Reset then single store: push addr 0x10, data 0xAAAA5555, `dm_hold`=0.
  - Next cycle: `dm_write`=1, `dm_address`=0x10, `dm_in`=0xAAAA5555.
  - Following cycle: `empty`=1.
- Fill and hold: `dm_hold`=1, push 4 stores to 0x0, 0x4, 0x8, 0xC.
  - `st_ready`=0 after the 4th; a 5th push is ignored.
  - Release `dm_hold`: writes appear in order, one per cycle, each with its PC; `st_ready` returns 1 after the first drain.
- Coalesce: `dm_hold`=1, push 0x20←1 then 0x23←2.
  - `count` stays 1.
  - After release, exactly one write to 0x20 with data 2 and the PC of the second store.
- Coalesce blocked: `count`=1 (0x40←5), `dm_hold`=0, push 0x40←6 in the same cycle.
  - Two writes: 0x40←5, then 0x40←6.
- Forwarding: `dm_hold`=1, buffer holds 0x8←1 and 0x8←7 (the second pushed with an intervening store to 0xC, so no coalesce), `dm_rdata`=0xDEAD.
  - `ld_addr`=0x8 gives `ld_data`=7, `ld_fwd`=1.
  - `ld_addr`=0x10 gives 0xDEAD, `ld_fwd`=0.
- Async reset mid-drain: 3 entries pending, pull `reset` low between edges.
  - `dm_write` drops immediately and `empty`=1.
  - After release, no stale writes occur.
